cp0_exception_unit: RTL and testbench
=====================================

Name: cp0_exception_unit

Overview:
- Consumer end of the exception vector that travels down the pipeline registers.
- Takes the MEM-stage ExceptinPipeType and picks the highest-priority exception.
- Updates the CP0 registers (BadVAddr, Count, Compare, Status, Cause, EPC), then asserts pipeline flush and redirects fetch to the handler or to EPC on ERET.
- Also produces the interrupt-pending signal that ID uses to set the Interrupt bit, closing the loop of the protocol.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, handler entry address.
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- MEM_ExceptType  in  9  ExceptinPipeType of the MEM-stage instruction
- MEM_PC  in  32  address of the MEM-stage instruction
- MEM_IsDelaySlot  in  1  MEM instruction is in a branch delay slot
- MEM_ALUOut  in  32  data address, used for load/store address errors
- Ext_Int  in  6  hardware interrupt lines, level-sensitive
- WB_CP0Wr  in  1  MTC0 write enable from WB
- WB_Dst  in  5  CP0 register number for the write
- WB_Sel  in  3  CP0 select for the write; only 0 is implemented
- WB_OutB  in  32  MTC0 write data
- CP0_RdAddr  in  5  MFC0 register number
- CP0_RdSel  in  3  MFC0 select
- CP0_RdData  out  32  MFC0 read data
- CP0_IntPending  out  1  interrupt should be tagged on the ID instruction
- Exc_Flush  out  1  flush IF/ID, ID/EXE, EXE/MEM and suppress the MEM writes
- Exc_Redirect  out  1  PC is loaded with Exc_NPC
- Exc_NPC  out  32  redirect target
- CP0_EPC  out  32  current EPC, for the ERET target

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - Status=STATUS_RST; Cause, EPC, Count, Compare, BadVAddr = 0; Count-divider toggle = 0.
  - While rst=1, all outputs are forced to 0 (CP0_EPC=0).
- Implemented fields:
  - Status: BEV[22], IM[15:8], EXL[1], IE[0].
  - Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2].
  - Unimplemented bits read 0.
- Exception priority, highest first, with ExcCode:
  1. Interrupt 0x00
  2. WrongAddressinIF 0x04, BadVAddr=MEM_PC
  3. ReservedInstruction 0x0A
  4. Overflow 0x0C
  5. Syscall 0x08
  6. Break 0x09
  7. RdWrongAddressinMEM 0x04, BadVAddr=MEM_ALUOut
  8. WrWrongAddressinMEM 0x05, BadVAddr=MEM_ALUOut
  9. Eret
- Exception taken (any bit other than Eret), effects at the next edge:
  - Cause.ExcCode updated; BadVAddr written for address errors only.
  - If Status.EXL=0: EPC = MEM_IsDelaySlot ? MEM_PC-4 : MEM_PC; Cause.BD = MEM_IsDelaySlot.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Status.EXL set to 1.
  - Same cycle, combinationally: Exc_Flush=1, Exc_Redirect=1, Exc_NPC=EXC_VECTOR.
- Eret only (no other bit set):
  - EXL cleared at the next edge.
  - Same cycle: Exc_Flush=1, Exc_Redirect=1, Exc_NPC=EPC. The EPC value includes a same-cycle MTC0 to EPC (bypass).
- No exception: Exc_Flush=0, Exc_Redirect=0, Exc_NPC=0.
- MTC0 in WB in the same cycle as an exception in MEM:
  - The WB write is applied first because it is the older instruction.
  - The exception update then overrides only the fields it owns.
- Writable fields: Status IM/EXL/IE; Cause IP[9:8]; EPC; Compare; Count; BadVAddr is read-only. Writes with WB_Sel≠0 are ignored.
- Count:
  - Increments every second cycle via the toggle.
  - An MTC0 Count write loads the value and takes precedence over the increment.
- Timer interrupt:
  - Count==Compare (registered values) sets TI to 1.
  - An MTC0 to Compare clears TI; the clear wins over a same-cycle set.
- Hardware interrupt lines: Cause.IP[15:10] <= {Ext_Int[5]|TI, Ext_Int[4:0]}, sampled every cycle.
- CP0_IntPending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), computed from registered values.
- CP0_RdData:
  - Register value, with same-cycle bypass of the WB write when address and select match.
  - Unimplemented register numbers return 0.

Decomposition:
- Package cp0_pkg holds:
  - CP0 register-number constants (8, 9, 11, 12, 13, 14).
  - ExcCode enum.
  - Packed Status and Cause structs.
  - EXC_VECTOR default.
- Sub-module cp0_exc_encoder (combinational): ExceptinPipeType in; exc_valid, is_eret, ExcCode and badvaddr_sel out.

Test Plan:
- Overflow bit with MEM_PC=0x8000_0100, not in delay slot, EXL=0 -> Exc_NPC=0xBFC0_0380; next cycle EPC=0x8000_0100, ExcCode=0x0C, EXL=1, BD=0.
- Syscall in delay slot at MEM_PC=0x8000_0204 -> EPC=0x8000_0200, BD=1; a second Syscall while EXL=1 -> EPC unchanged, ExcCode=0x08.
- RdWrongAddressinMEM with MEM_ALUOut=0x0000_0003, ReservedInstruction also set -> ExcCode=0x0A, BadVAddr unchanged. Repeat with the address error alone -> ExcCode=0x04, BadVAddr=0x3.
- MTC0 Compare=10, Count=0, IM[7]=1, IE=1 -> TI set once Count==10 (about 20 cycles later), CP0_IntPending=1. MTC0 Compare then clears TI.
- Same-cycle MTC0 EPC=0x8000_1000 in WB and Eret in MEM -> Exc_NPC=0x8000_1000; EXL=0 next cycle.
- rst asserted mid-exception with EXL=1 -> next cycle Status=0x0040_0000, Exc_Flush=0, Count restarts from 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 register numbers, exception codes and register layouts
package cp0_pkg;

    // CP0 register numbers (select 0 only)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC_REG  = 5'd14;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

    // Bit positions inside the ExceptinPipeType vector, highest priority first
    localparam int EXC_BIT_INT  = 8;
    localparam int EXC_BIT_IF   = 7;
    localparam int EXC_BIT_RI   = 6;
    localparam int EXC_BIT_OV   = 5;
    localparam int EXC_BIT_SYS  = 4;
    localparam int EXC_BIT_BRK  = 3;
    localparam int EXC_BIT_RD   = 2;
    localparam int EXC_BIT_WR   = 1;
    localparam int EXC_BIT_ERET = 0;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } exc_code_e;

    // Which address lands in BadVAddr when the exception is taken
    typedef enum logic [1:0] {
        BVA_NONE = 2'd0,
        BVA_PC   = 2'd1,
        BVA_ALU  = 2'd2
    } badvaddr_sel_e;

    typedef struct packed {
        logic [8:0] rsv_31_23;
        logic       bev;
        logic [5:0] rsv_21_16;
        logic [7:0] im;
        logic [5:0] rsv_7_2;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] rsv_29_16;
        logic [7:0]  ip;
        logic        rsv_7;
        logic [4:0]  exc_code;
        logic [1:0]  rsv_1_0;
    } cause_t;

endpackage

// File: rtl/cp0_exc_encoder.sv
// rtl/cp0_exc_encoder.sv - priority encoder from ExceptinPipeType to ExcCode
module cp0_exc_encoder
    import cp0_pkg::*;
(
    input  logic [8:0] except_type,
    output logic       exc_valid,
    output logic       is_eret,
    output logic [4:0] exc_code,
    output logic [1:0] badvaddr_sel
);

    // Eret only counts when nothing else is pending; any other bit is a real exception
    assign exc_valid = |except_type[8:1];
    assign is_eret   = except_type[EXC_BIT_ERET] & ~(|except_type[8:1]);

    // Highest-priority set bit decides the code and the BadVAddr source
    always_comb begin
        exc_code     = EXC_INT;
        badvaddr_sel = BVA_NONE;
        if (except_type[EXC_BIT_INT]) begin
            exc_code = EXC_INT;
        end else if (except_type[EXC_BIT_IF]) begin
            exc_code     = EXC_ADEL;
            badvaddr_sel = BVA_PC;
        end else if (except_type[EXC_BIT_RI]) begin
            exc_code = EXC_RI;
        end else if (except_type[EXC_BIT_OV]) begin
            exc_code = EXC_OV;
        end else if (except_type[EXC_BIT_SYS]) begin
            exc_code = EXC_SYS;
        end else if (except_type[EXC_BIT_BRK]) begin
            exc_code = EXC_BP;
        end else if (except_type[EXC_BIT_RD]) begin
            exc_code     = EXC_ADEL;
            badvaddr_sel = BVA_ALU;
        end else if (except_type[EXC_BIT_WR]) begin
            exc_code     = EXC_ADES;
            badvaddr_sel = BVA_ALU;
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 registers, exception commit, flush and redirect
module cp0_exception_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  MEM_ExceptType,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_IsDelaySlot,
    input  logic [31:0] MEM_ALUOut,
    input  logic [5:0]  Ext_Int,
    input  logic        WB_CP0Wr,
    input  logic [4:0]  WB_Dst,
    input  logic [2:0]  WB_Sel,
    input  logic [31:0] WB_OutB,
    input  logic [4:0]  CP0_RdAddr,
    input  logic [2:0]  CP0_RdSel,
    output logic [31:0] CP0_RdData,
    output logic        CP0_IntPending,
    output logic        Exc_Flush,
    output logic        Exc_Redirect,
    output logic [31:0] Exc_NPC,
    output logic [31:0] CP0_EPC
);

    status_t     status_q, status_w, status_n;
    cause_t      cause_q, cause_w, cause_n;
    logic [31:0] epc_q, epc_w, epc_n;
    logic [31:0] count_q, count_w, count_n;
    logic [31:0] compare_q, compare_w;
    logic [31:0] badvaddr_q, badvaddr_n;
    logic        toggle_q;

    logic        exc_valid;
    logic        is_eret;
    logic [4:0]  enc_code;
    logic [1:0]  enc_bva_sel;

    logic        wr_sel0;
    logic        wr_status, wr_cause, wr_epc, wr_count, wr_compare;

    cp0_exc_encoder u_encoder (
        .except_type  (MEM_ExceptType),
        .exc_valid    (exc_valid),
        .is_eret      (is_eret),
        .exc_code     (enc_code),
        .badvaddr_sel (enc_bva_sel)
    );

    assign wr_sel0    = WB_CP0Wr && (WB_Sel == 3'd0);
    assign wr_status  = wr_sel0 && (WB_Dst == CP0_STATUS);
    assign wr_cause   = wr_sel0 && (WB_Dst == CP0_CAUSE);
    assign wr_epc     = wr_sel0 && (WB_Dst == CP0_EPC_REG);
    assign wr_count   = wr_sel0 && (WB_Dst == CP0_COUNT);
    assign wr_compare = wr_sel0 && (WB_Dst == CP0_COMPARE);

    // Older WB MTC0 applied first; these values also serve the read bypass
    always_comb begin
        status_w = status_q;
        cause_w  = cause_q;
        if (wr_status) begin
            status_w.im  = WB_OutB[15:8];
            status_w.exl = WB_OutB[1];
            status_w.ie  = WB_OutB[0];
        end
        if (wr_cause) begin
            cause_w.ip[1:0] = WB_OutB[9:8];
        end
        epc_w     = wr_epc     ? WB_OutB : epc_q;
        count_w   = wr_count   ? WB_OutB : count_q;
        compare_w = wr_compare ? WB_OutB : compare_q;
    end

    // Exception commit on top of the WB write, plus timer and interrupt sampling
    always_comb begin
        status_n   = status_w;
        cause_n    = cause_w;
        epc_n      = epc_w;
        badvaddr_n = badvaddr_q;

        cause_n.ip[7:2] = {Ext_Int[5] | cause_q.ti, Ext_Int[4:0]};
        if (wr_compare) begin
            cause_n.ti = 1'b0;
        end else if (count_q == compare_q) begin
            cause_n.ti = 1'b1;
        end

        if (exc_valid) begin
            cause_n.exc_code = enc_code;
            if (enc_bva_sel == BVA_PC) begin
                badvaddr_n = MEM_PC;
            end else if (enc_bva_sel == BVA_ALU) begin
                badvaddr_n = MEM_ALUOut;
            end
            // Nested exceptions keep the original return point
            if (!status_w.exl) begin
                epc_n      = MEM_IsDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
                cause_n.bd = MEM_IsDelaySlot;
            end
            status_n.exl = 1'b1;
        end else if (is_eret) begin
            status_n.exl = 1'b0;
        end

        count_n = wr_count ? WB_OutB : (count_q + {31'd0, toggle_q});
    end

    // CP0 state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= status_t'(STATUS_RST);
            cause_q    <= '0;
            epc_q      <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            badvaddr_q <= '0;
            toggle_q   <= 1'b0;
        end else begin
            status_q   <= status_n;
            cause_q    <= cause_n;
            epc_q      <= epc_n;
            count_q    <= count_n;
            compare_q  <= compare_w;
            badvaddr_q <= badvaddr_n;
            toggle_q   <= ~toggle_q;
        end
    end

    // Flush/redirect, MFC0 read mux and interrupt pending; all zero while in reset
    always_comb begin
        CP0_RdData     = '0;
        CP0_IntPending = 1'b0;
        Exc_Flush      = 1'b0;
        Exc_Redirect   = 1'b0;
        Exc_NPC        = '0;
        CP0_EPC        = '0;
        if (!rst) begin
            CP0_EPC        = epc_q;
            CP0_IntPending = status_q.ie & ~status_q.exl & (|(cause_q.ip & status_q.im));
            if (exc_valid) begin
                Exc_Flush    = 1'b1;
                Exc_Redirect = 1'b1;
                Exc_NPC      = EXC_VECTOR;
            end else if (is_eret) begin
                Exc_Flush    = 1'b1;
                Exc_Redirect = 1'b1;
                Exc_NPC      = epc_w;
            end
            if (CP0_RdSel == 3'd0) begin
                case (CP0_RdAddr)
                    CP0_BADVADDR: CP0_RdData = badvaddr_q;
                    CP0_COUNT:    CP0_RdData = count_w;
                    CP0_COMPARE:  CP0_RdData = compare_w;
                    CP0_STATUS:   CP0_RdData = status_w;
                    CP0_CAUSE:    CP0_RdData = cause_w;
                    CP0_EPC_REG:  CP0_RdData = epc_w;
                    default:      CP0_RdData = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - directed vector bench for cp0_exception_unit
module tb_cp0_exception_unit;
    import cp0_pkg::*;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam logic [8:0] T_INT = 9'h100, T_IF = 9'h080, T_RI = 9'h040, T_OV = 9'h020,
                           T_SYS = 9'h010, T_BRK = 9'h008, T_RD = 9'h004, T_WR = 9'h002,
                           T_ERET = 9'h001;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  MEM_ExceptType;
    logic [31:0] MEM_PC;
    logic        MEM_IsDelaySlot;
    logic [31:0] MEM_ALUOut;
    logic [5:0]  Ext_Int;
    logic        WB_CP0Wr;
    logic [4:0]  WB_Dst;
    logic [2:0]  WB_Sel;
    logic [31:0] WB_OutB;
    logic [4:0]  CP0_RdAddr;
    logic [2:0]  CP0_RdSel;
    logic [31:0] CP0_RdData;
    logic        CP0_IntPending;
    logic        Exc_Flush;
    logic        Exc_Redirect;
    logic [31:0] Exc_NPC;
    logic [31:0] CP0_EPC;

    int n_chk  = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    cp0_exception_unit dut (
        .clk             (clk),
        .rst             (rst),
        .MEM_ExceptType  (MEM_ExceptType),
        .MEM_PC          (MEM_PC),
        .MEM_IsDelaySlot (MEM_IsDelaySlot),
        .MEM_ALUOut      (MEM_ALUOut),
        .Ext_Int         (Ext_Int),
        .WB_CP0Wr        (WB_CP0Wr),
        .WB_Dst          (WB_Dst),
        .WB_Sel          (WB_Sel),
        .WB_OutB         (WB_OutB),
        .CP0_RdAddr      (CP0_RdAddr),
        .CP0_RdSel       (CP0_RdSel),
        .CP0_RdData      (CP0_RdData),
        .CP0_IntPending  (CP0_IntPending),
        .Exc_Flush       (Exc_Flush),
        .Exc_Redirect    (Exc_Redirect),
        .Exc_NPC         (Exc_NPC),
        .CP0_EPC         (CP0_EPC)
    );

    typedef struct {
        logic [8:0]  et;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] alu;
        logic [31:0] npc;
        logic        flush;
        logic [31:0] epc;
        logic [4:0]  code;
        logic        exl;
        logic        bd;
        logic [31:0] bva;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        CP0_RdAddr = a;
        CP0_RdSel  = 3'd0;
        #1;
        d = CP0_RdData;
    endtask

    task automatic idle();
        MEM_ExceptType  = '0;
        MEM_PC          = '0;
        MEM_IsDelaySlot = 1'b0;
        MEM_ALUOut      = '0;
        WB_CP0Wr        = 1'b0;
        WB_Dst          = '0;
        WB_Sel          = '0;
        WB_OutB         = '0;
    endtask

    task automatic mtc0(input logic [4:0] dst, input logic [31:0] data);
        @(negedge clk);
        WB_CP0Wr = 1'b1;
        WB_Dst   = dst;
        WB_Sel   = 3'd0;
        WB_OutB  = data;
        @(posedge clk);
        #1;
        idle();
    endtask

    logic [31:0] d;
    int          k;

    initial begin
        vt[0]  = '{T_OV,          32'h8000_0100, 1'b0, 32'h0,  VEC,           1'b1, 32'h8000_0100, 5'h0C, 1'b1, 1'b0, 32'h0};
        vt[1]  = '{T_ERET,        32'h8000_0180, 1'b0, 32'h0,  32'h8000_0100, 1'b1, 32'h8000_0100, 5'h0C, 1'b0, 1'b0, 32'h0};
        vt[2]  = '{T_SYS,         32'h8000_0204, 1'b1, 32'h0,  VEC,           1'b1, 32'h8000_0200, 5'h08, 1'b1, 1'b1, 32'h0};
        vt[3]  = '{T_SYS,         32'h8000_0300, 1'b0, 32'h0,  VEC,           1'b1, 32'h8000_0200, 5'h08, 1'b1, 1'b1, 32'h0};
        vt[4]  = '{T_ERET,        32'h8000_0380, 1'b0, 32'h0,  32'h8000_0200, 1'b1, 32'h8000_0200, 5'h08, 1'b0, 1'b1, 32'h0};
        vt[5]  = '{T_RD | T_RI,   32'h8000_0400, 1'b0, 32'h3,  VEC,           1'b1, 32'h8000_0400, 5'h0A, 1'b1, 1'b0, 32'h0};
        vt[6]  = '{T_ERET,        32'h8000_0480, 1'b0, 32'h0,  32'h8000_0400, 1'b1, 32'h8000_0400, 5'h0A, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{T_RD,          32'h8000_0500, 1'b0, 32'h3,  VEC,           1'b1, 32'h8000_0500, 5'h04, 1'b1, 1'b0, 32'h3};
        vt[8]  = '{T_WR | T_BRK,  32'h8000_0600, 1'b0, 32'h10, VEC,           1'b1, 32'h8000_0500, 5'h09, 1'b1, 1'b0, 32'h3};
        vt[9]  = '{T_WR,          32'h8000_0700, 1'b0, 32'h11, VEC,           1'b1, 32'h8000_0500, 5'h05, 1'b1, 1'b0, 32'h11};
        vt[10] = '{T_IF | T_OV,   32'h8000_0803, 1'b0, 32'h0,  VEC,           1'b1, 32'h8000_0500, 5'h04, 1'b1, 1'b0, 32'h8000_0803};
        vt[11] = '{T_ERET | T_SYS,32'h8000_0880, 1'b0, 32'h0,  VEC,           1'b1, 32'h8000_0500, 5'h08, 1'b1, 1'b0, 32'h8000_0803};
        vt[12] = '{T_INT | T_IF,  32'h8000_0900, 1'b0, 32'h55, VEC,           1'b1, 32'h8000_0500, 5'h00, 1'b1, 1'b0, 32'h8000_0803};
        vt[13] = '{T_ERET,        32'h8000_0980, 1'b0, 32'h0,  32'h8000_0500, 1'b1, 32'h8000_0500, 5'h00, 1'b0, 1'b0, 32'h8000_0803};
        vt[14] = '{9'h000,        32'h8000_0A00, 1'b0, 32'h0,  32'h0,         1'b0, 32'h8000_0500, 5'h00, 1'b0, 1'b0, 32'h8000_0803};

        // Reset: outputs forced low, then reset values visible
        rst = 1'b1;
        Ext_Int = '0;
        CP0_RdAddr = CP0_STATUS;
        CP0_RdSel = 3'd0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        MEM_ExceptType = T_OV;
        #1;
        chk("rst_flush", {31'd0, Exc_Flush}, 32'd0);
        chk("rst_npc", Exc_NPC, 32'd0);
        chk("rst_rddata", CP0_RdData, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        rd(CP0_STATUS, d);  chk("reset_status", d, 32'h0040_0000);
        rd(CP0_CAUSE, d);   chk("reset_cause", d, 32'h0);
        rd(CP0_COUNT, d);   chk("reset_count", d, 32'h0);
        rd(CP0_EPC_REG, d); chk("reset_epc", d, 32'h0);

        // Timer interrupt via Compare/Count/Status writes
        @(negedge clk);
        WB_CP0Wr = 1'b1; WB_Dst = CP0_COMPARE; WB_Sel = 3'd0; WB_OutB = 32'd10;
        CP0_RdAddr = CP0_COMPARE;
        #1;
        chk("compare_bypass", CP0_RdData, 32'd10);
        @(posedge clk);
        #1;
        idle();
        mtc0(CP0_COUNT, 32'd0);
        mtc0(CP0_STATUS, 32'h0000_8001);
        rd(CP0_CAUSE, d);
        chk("ti_cleared", {31'd0, d[30]}, 32'd0);
        k = 0;
        while (k < 40 && !CP0_IntPending) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("timer_latency_ok", {31'd0, (k >= 17 && k <= 24)}, 32'd1);
        chk("int_pending", {31'd0, CP0_IntPending}, 32'd1);
        rd(CP0_CAUSE, d);
        chk("ti_set", {31'd0, d[30]}, 32'd1);
        mtc0(CP0_COMPARE, 32'd100);
        rd(CP0_CAUSE, d);
        chk("ti_clear_on_compare", {31'd0, d[30]}, 32'd0);
        @(posedge clk);
        #1;
        chk("int_pending_drop", {31'd0, CP0_IntPending}, 32'd0);
        mtc0(CP0_STATUS, 32'h0);

        // Table-driven exception vectors
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            MEM_ExceptType  = vt[i].et;
            MEM_PC          = vt[i].pc;
            MEM_IsDelaySlot = vt[i].ds;
            MEM_ALUOut      = vt[i].alu;
            #1;
            chk($sformatf("v%0d_npc", i), Exc_NPC, vt[i].npc);
            chk($sformatf("v%0d_flush", i), {31'd0, Exc_Flush}, {31'd0, vt[i].flush});
            chk($sformatf("v%0d_redirect", i), {31'd0, Exc_Redirect}, {31'd0, vt[i].flush});
            @(posedge clk);
            #1;
            idle();
            rd(CP0_STATUS, d);
            chk($sformatf("v%0d_status", i), d, {30'h0010_0000, vt[i].exl, 1'b0});
            rd(CP0_CAUSE, d);
            chk($sformatf("v%0d_cause", i), d & 32'h8000_007C, {vt[i].bd, 24'h0, vt[i].code, 2'b00});
            rd(CP0_EPC_REG, d);
            chk($sformatf("v%0d_epc", i), d, vt[i].epc);
            rd(CP0_BADVADDR, d);
            chk($sformatf("v%0d_badvaddr", i), d, vt[i].bva);
        end

        // Same-cycle MTC0 EPC in WB with Eret in MEM
        @(negedge clk);
        MEM_ExceptType = T_SYS; MEM_PC = 32'h8000_0B00;
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        MEM_ExceptType = T_ERET;
        WB_CP0Wr = 1'b1; WB_Dst = CP0_EPC_REG; WB_Sel = 3'd0; WB_OutB = 32'h8000_1000;
        #1;
        chk("eret_bypass_npc", Exc_NPC, 32'h8000_1000);
        chk("eret_bypass_flush", {31'd0, Exc_Flush}, 32'd1);
        @(posedge clk);
        #1;
        idle();
        rd(CP0_EPC_REG, d); chk("eret_bypass_epc", d, 32'h8000_1000);
        rd(CP0_STATUS, d);  chk("eret_bypass_exl", d, 32'h0040_0000);
        chk("cp0_epc_out", CP0_EPC, 32'h8000_1000);

        // Reset while an exception is in flight with EXL=1
        @(negedge clk);
        MEM_ExceptType = T_OV; MEM_PC = 32'h8000_0C00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_flush", {31'd0, Exc_Flush}, 32'd0);
        chk("rst_mid_epc_out", CP0_EPC, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        rd(CP0_STATUS, d); chk("rst_mid_status", d, 32'h0040_0000);
        rd(CP0_COUNT, d);  chk("rst_mid_count0", d, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rd(CP0_COUNT, d);  chk("count_after_2", d, 32'd1);
        @(negedge clk);
        WB_CP0Wr = 1'b1; WB_Dst = CP0_COUNT; WB_Sel = 3'd1; WB_OutB = 32'h1234;
        rd(CP0_COUNT, d);  chk("sel1_no_bypass", d, 32'd1);
        @(posedge clk);
        #1;
        idle();
        rd(CP0_COUNT, d);  chk("sel1_ignored", d, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
